nibble_pack_sched: RTL and testbench
====================================

Name: nibble_pack_sched

Overview:
- Joins one 8-bit A operand and one 7-bit B operand into a single transaction and emits 8-bit output beats built from nibble slices and concatenations of the pair.
- Sequences a one- or two-beat output burst, selected per pair by a mode field.
- Sits between two independent operand producers and a single byte-wide consumer, and owns all slice/concat scheduling for that path.

Parameters:
CNT_W, 16, width of the completed-pair counter (wraps modulo 2**CNT_W)

Ports:
clk  in  1  clock; all logic on rising edge
rst  in  1  synchronous, active-high reset
a_valid  in  1  A operand valid
a_ready  out  1  A operand accepted this cycle
a_data  in  8  A operand
b_valid  in  1  B operand valid
b_ready  out  1  B operand accepted this cycle
b_data  in  7  B operand
mode  in  2  burst format, sampled with the pair
d_valid  out  1  output beat valid
d_ready  in  1  consumer accepts beat
d_data  out  8  output beat
d_last  out  1  final beat of current pair
c_out  out  2  captured a_data[3:2], held for the whole burst
busy  out  1  a pair is held (state != IDLE)
pair_count  out  CNT_W  number of completed pairs

Behaviour:
- Reset: state=IDLE, d_valid=0, d_last=0, d_data=0, c_out=0, busy=0, pair_count=0, capture regs=0. a_ready/b_ready are combinational and therefore 0 under reset.
- space = (state==IDLE) | (d_valid & d_ready & d_last).
- load = space & a_valid & b_valid & ~rst.
- a_ready = b_ready = load. Both operands always transfer together; a lone valid is never consumed.
- On load: register a_data, b_data and mode; c_out <= a_data[3:2]; go to BEAT0. d_valid rises the cycle after the capture edge (1-cycle latency).
- States: IDLE, BEAT0, BEAT1.
- Beat formats, from the captured A (a) and B (b):
  - mode 0 SPLIT: 1 beat, d_data={b[6:3],a[3:0]}, d_last=1.
  - mode 1 SWAP2: BEAT0 {a[3:0],b[3:0]} with d_last=0, then BEAT1 {b[3:0],a[7:4]} with d_last=1.
  - mode 2 PASS_A: 1 beat, d_data=a, d_last=1.
  - mode 3 PASS_B: 1 beat, d_data={1'b0,b}, d_last=1.
- Transitions:
  - BEAT0, accept, mode 1 -> BEAT1.
  - BEAT0 or BEAT1, accept of the last beat -> BEAT0 if load, else IDLE.
- Back-to-back: a new pair captured on the edge that accepts the last beat gives zero bubble. Throughput is 1 pair/cycle in single-beat modes and 1 pair/2 cycles in mode 1.
- Backpressure: while d_valid & ~d_ready, d_data, d_last and c_out hold stable and no capture occurs.
- mode changes between captures have no effect on a burst in flight.
- pair_count increments by 1 on each accepted last beat and wraps to 0 at 2**CNT_W.
- Reset mid-burst: the held pair is discarded and all outputs return to reset values on the next edge. No partial count is kept.
- Simultaneous last-beat accept and new pair: the count increments and the new pair is captured on the same edge.

Decomposition:
- Shared package nibble_pack_pkg:
  - mode_e enum: MODE_SPLIT=0, MODE_SWAP2=1, MODE_PASS_A=2, MODE_PASS_B=3.
  - state_e enum: IDLE, BEAT0, BEAT1.
  - Width constants A_W=8, B_W=7, D_W=8.
- Sub-module nibble_beat_fmt: purely combinational (captured a, b, mode, beat index) -> (data, last). Keeping the slice/concat table here leaves the FSM free of bit manipulation.

Test Plan:
- Mode 1 burst: a=8'b0000_1110, b=7'b111_1111, d_ready=1 -> beats 8'hEF (last=0) then 8'hF0 (last=1); c_out=2'b11; pair_count=1.
- Mode 0: a=8'b1111_0101, b=7'b111_1111 -> single beat 8'hF5, last=1; c_out=2'b01. Mode 2 with a=8'hF8 -> 8'hF8. Mode 3 with b=7'h7F -> 8'h7F.
- Backpressure: mode 1 pair with d_ready=0 for 3 cycles during BEAT0 -> d_data held at 8'hEF, a_ready=0, and the pending A/B valids are not consumed until the last beat is accepted.
- Back-to-back: 4 mode-0 pairs presented continuously with d_ready=1 -> 4 consecutive d_valid cycles, no bubble; pair_count=4. Mixed mode-1 stream -> exactly 2 cycles per pair.
- Join: a_valid=1 with b_valid=0 for 5 cycles -> a_ready stays 0 and no output. Raising b_valid captures on that edge.
- Wrap and reset: with CNT_W=2, 4 pairs -> pair_count returns to 0. Asserting rst during BEAT1 -> next cycle d_valid=0, busy=0, pair_count=0, and the discarded pair never appears.

Source files
------------

// File: rtl/nibble_pack_pkg.sv
// Shared types and width constants for the nibble pack scheduler.
package nibble_pack_pkg;

    localparam int A_W = 8;
    localparam int B_W = 7;
    localparam int D_W = 8;

    typedef enum logic [1:0] {
        MODE_SPLIT  = 2'd0,
        MODE_SWAP2  = 2'd1,
        MODE_PASS_A = 2'd2,
        MODE_PASS_B = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } state_e;

endpackage

// File: rtl/nibble_beat_fmt.sv
// Slice/concat table: turns a captured A/B pair, its mode and the beat index
// into one output byte plus its last-beat flag.
module nibble_beat_fmt
    import nibble_pack_pkg::*;
(
    input  logic [A_W-1:0] i_a,
    input  logic [B_W-1:0] i_b,
    input  mode_e          i_mode,
    input  logic           i_beat,
    output logic [D_W-1:0] o_data,
    output logic           o_last
);

    // Select the beat layout; only the two-beat swap format looks at the beat index.
    always_comb begin
        o_data = '0;
        o_last = 1'b1;
        case (i_mode)
            MODE_SPLIT: begin
                o_data = {i_b[6:3], i_a[3:0]};
            end
            MODE_SWAP2: begin
                if (i_beat) begin
                    o_data = {i_b[3:0], i_a[7:4]};
                    o_last = 1'b1;
                end else begin
                    o_data = {i_a[3:0], i_b[3:0]};
                    o_last = 1'b0;
                end
            end
            MODE_PASS_A: begin
                o_data = i_a;
            end
            MODE_PASS_B: begin
                o_data = {1'b0, i_b};
            end
            default: begin
                o_data = '0;
                o_last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/nibble_pack_sched.sv
// Joins an A and a B operand into one pair and plays it out as a one- or
// two-beat byte burst, with zero-bubble hand-off between consecutive pairs.
module nibble_pack_sched
    import nibble_pack_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_a_valid,
    output logic             o_a_ready,
    input  logic [A_W-1:0]   i_a_data,
    input  logic             i_b_valid,
    output logic             o_b_ready,
    input  logic [B_W-1:0]   i_b_data,
    input  logic [1:0]       i_mode,
    output logic             o_d_valid,
    input  logic             i_d_ready,
    output logic [D_W-1:0]   o_d_data,
    output logic             o_d_last,
    output logic [1:0]       o_c_out,
    output logic             o_busy,
    output logic [CNT_W-1:0] o_pair_count
);

    state_e           r_state;
    logic [A_W-1:0]   r_a;
    logic [B_W-1:0]   r_b;
    mode_e            r_mode;
    logic [1:0]       r_c;
    logic             r_d_valid;
    logic [D_W-1:0]   r_d_data;
    logic             r_d_last;
    logic [CNT_W-1:0] r_count;

    logic             w_accept;
    logic             w_done;
    logic             w_space;
    logic             w_load;
    logic             w_adv;
    logic [A_W-1:0]   w_fmt_a;
    logic [B_W-1:0]   w_fmt_b;
    mode_e            w_fmt_mode;
    logic             w_fmt_beat;
    logic [D_W-1:0]   w_fmt_data;
    logic             w_fmt_last;

    assign w_accept = r_d_valid & i_d_ready;
    assign w_done   = w_accept & r_d_last;
    assign w_space  = (r_state == IDLE) | w_done;
    assign w_load   = w_space & i_a_valid & i_b_valid & ~i_rst;
    assign w_adv    = w_accept & ~r_d_last;

    // The formatter sees the incoming pair when loading (beat 0), otherwise
    // the held pair for its second beat, so the beat byte can be registered.
    assign w_fmt_a    = w_load ? i_a_data : r_a;
    assign w_fmt_b    = w_load ? i_b_data : r_b;
    assign w_fmt_mode = w_load ? mode_e'(i_mode) : r_mode;
    assign w_fmt_beat = ~w_load;

    nibble_beat_fmt u_fmt (
        .i_a    (w_fmt_a),
        .i_b    (w_fmt_b),
        .i_mode (w_fmt_mode),
        .i_beat (w_fmt_beat),
        .o_data (w_fmt_data),
        .o_last (w_fmt_last)
    );

    // Burst sequencer: capture on load, step to the second beat, count completed pairs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_mode    <= MODE_SPLIT;
            r_c       <= '0;
            r_d_valid <= 1'b0;
            r_d_data  <= '0;
            r_d_last  <= 1'b0;
            r_count   <= '0;
        end else begin
            if (w_done) begin
                r_count <= r_count + CNT_W'(1);
            end
            if (w_load) begin
                r_a       <= i_a_data;
                r_b       <= i_b_data;
                r_mode    <= mode_e'(i_mode);
                r_c       <= i_a_data[3:2];
                r_state   <= BEAT0;
                r_d_valid <= 1'b1;
                r_d_data  <= w_fmt_data;
                r_d_last  <= w_fmt_last;
            end else if (w_adv) begin
                r_state   <= BEAT1;
                r_d_data  <= w_fmt_data;
                r_d_last  <= w_fmt_last;
            end else if (w_done) begin
                r_state   <= IDLE;
                r_d_valid <= 1'b0;
                r_d_last  <= 1'b0;
            end
        end
    end

    assign o_a_ready    = w_load;
    assign o_b_ready    = w_load;
    assign o_d_valid    = r_d_valid;
    assign o_d_data     = r_d_data;
    assign o_d_last     = r_d_last;
    assign o_c_out      = r_c;
    assign o_busy       = (r_state != IDLE);
    assign o_pair_count = r_count;

endmodule

// File: tb/tb_nibble_pack_sched.sv
// Directed bench for nibble_pack_sched; a second instance with a 2-bit
// counter shares the stimulus to exercise counter wrap.
module tb_nibble_pack_sched;

    logic       clk;
    logic       rst;
    logic       aValid;
    logic [7:0] aData;
    logic       bValid;
    logic [6:0] bData;
    logic [1:0] mode;
    logic       dReady;

    logic        aReady, bReady, dValid, dLast, busy;
    logic [7:0]  dData;
    logic [1:0]  cOut;
    logic [15:0] pairCount;

    logic        aReadyW, bReadyW, dValidW, dLastW, busyW;
    logic [7:0]  dDataW;
    logic [1:0]  cOutW;
    logic [1:0]  pairCountW;

    int checkCount = 0;
    int passCount  = 0;

    nibble_pack_sched #(.CNT_W(16)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(aValid), .o_a_ready(aReady), .i_a_data(aData),
        .i_b_valid(bValid), .o_b_ready(bReady), .i_b_data(bData),
        .i_mode(mode),
        .o_d_valid(dValid), .i_d_ready(dReady), .o_d_data(dData), .o_d_last(dLast),
        .o_c_out(cOut), .o_busy(busy), .o_pair_count(pairCount)
    );

    nibble_pack_sched #(.CNT_W(2)) dutW (
        .i_clk(clk), .i_rst(rst),
        .i_a_valid(aValid), .o_a_ready(aReadyW), .i_a_data(aData),
        .i_b_valid(bValid), .o_b_ready(bReadyW), .i_b_data(bData),
        .i_mode(mode),
        .o_d_valid(dValidW), .i_d_ready(dReady), .o_d_data(dDataW), .o_d_last(dLastW),
        .o_c_out(cOutW), .o_busy(busyW), .o_pair_count(pairCountW)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [7:0] a, input logic [6:0] b, input logic [1:0] m);
        aValid = 1'b1; bValid = 1'b1; aData = a; bData = b; mode = m;
    endtask

    task automatic idleInputs();
        aValid = 1'b0; bValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; dReady = 1'b1;
        present(8'hFF, 7'h7F, 2'd1);
        tick(); tick();
        checkCount++; if (aReady !== 1'b0) $display("[TB] FAIL rst_a_ready got %0b want 0", aReady); else passCount++;
        checkCount++; if (bReady !== 1'b0) $display("[TB] FAIL rst_b_ready got %0b want 0", bReady); else passCount++;
        checkCount++; if (dValid !== 1'b0) $display("[TB] FAIL rst_d_valid got %0b want 0", dValid); else passCount++;
        checkCount++; if ({dLast, dData, cOut, busy} !== 12'h000) $display("[TB] FAIL rst_outputs got last=%0b data=%h c=%0d busy=%0b want all 0", dLast, dData, cOut, busy); else passCount++;
        checkCount++; if (pairCount !== 16'd0) $display("[TB] FAIL rst_count got %0d want 0", pairCount); else passCount++;
        idleInputs();
        rst = 1'b0;
        tick();
        checkCount++; if (dValid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL post_rst_idle got valid=%0b busy=%0b want 0 0", dValid, busy); else passCount++;
    endtask

    task automatic test_swap2();
        dReady = 1'b1;
        present(8'b0000_1110, 7'b111_1111, 2'd1);
        #1;
        checkCount++; if (aReady !== 1'b1 || bReady !== 1'b1) $display("[TB] FAIL swap2_ready got a=%0b b=%0b want 1 1", aReady, bReady); else passCount++;
        tick();
        idleInputs();
        checkCount++; if ({dValid, dLast, dData} !== {1'b1, 1'b0, 8'hEF}) $display("[TB] FAIL swap2_beat0 got v=%0b l=%0b d=%h want v=1 l=0 d=ef", dValid, dLast, dData); else passCount++;
        checkCount++; if (cOut !== 2'b11 || busy !== 1'b1) $display("[TB] FAIL swap2_c_busy got c=%0d busy=%0b want 3 1", cOut, busy); else passCount++;
        tick();
        checkCount++; if ({dValid, dLast, dData} !== {1'b1, 1'b1, 8'hF0}) $display("[TB] FAIL swap2_beat1 got v=%0b l=%0b d=%h want v=1 l=1 d=f0", dValid, dLast, dData); else passCount++;
        checkCount++; if (cOut !== 2'b11) $display("[TB] FAIL swap2_c_hold got %0d want 3", cOut); else passCount++;
        tick();
        checkCount++; if (dValid !== 1'b0 || busy !== 1'b0) $display("[TB] FAIL swap2_idle got v=%0b busy=%0b want 0 0", dValid, busy); else passCount++;
        checkCount++; if (pairCount !== 16'd1) $display("[TB] FAIL swap2_count got %0d want 1", pairCount); else passCount++;
    endtask

    task automatic test_single_modes();
        logic [7:0] vecA   [3] = '{8'hF5, 8'hF8, 8'h00};
        logic [6:0] vecB   [3] = '{7'h7F, 7'h00, 7'h7F};
        logic [1:0] vecM   [3] = '{2'd0,  2'd2,  2'd3};
        logic [7:0] vecExp [3] = '{8'hF5, 8'hF8, 8'h7F};
        logic [1:0] vecC   [3] = '{2'b01, 2'b10, 2'b00};
        dReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(vecA[i], vecB[i], vecM[i]);
            tick();
            idleInputs();
            checkCount++; if ({dValid, dLast, dData} !== {1'b1, 1'b1, vecExp[i]}) $display("[TB] FAIL single_beat%0d got v=%0b l=%0b d=%h want v=1 l=1 d=%h", i, dValid, dLast, dData, vecExp[i]); else passCount++;
            checkCount++; if (cOut !== vecC[i]) $display("[TB] FAIL single_c%0d got %0d want %0d", i, cOut, vecC[i]); else passCount++;
            tick();
            checkCount++; if (dValid !== 1'b0) $display("[TB] FAIL single_idle%0d got %0b want 0", i, dValid); else passCount++;
        end
        checkCount++; if (pairCount !== 16'd4) $display("[TB] FAIL single_count got %0d want 4", pairCount); else passCount++;
        checkCount++; if (pairCountW !== 2'd0) $display("[TB] FAIL wrap_count got %0d want 0", pairCountW); else passCount++;
    endtask

    task automatic test_backpressure();
        dReady = 1'b0;
        present(8'b0000_1110, 7'b111_1111, 2'd1);
        tick();
        present(8'hF5, 7'h7F, 2'd0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checkCount++; if ({dValid, dLast, dData} !== {1'b1, 1'b0, 8'hEF}) $display("[TB] FAIL bp_hold%0d got v=%0b l=%0b d=%h want v=1 l=0 d=ef", i, dValid, dLast, dData); else passCount++;
            checkCount++; if (aReady !== 1'b0 || cOut !== 2'b11) $display("[TB] FAIL bp_ready%0d got a_ready=%0b c=%0d want 0 3", i, aReady, cOut); else passCount++;
            tick();
        end
        dReady = 1'b1;
        #1;
        checkCount++; if (aReady !== 1'b0) $display("[TB] FAIL bp_beat0_ready got %0b want 0", aReady); else passCount++;
        tick();
        checkCount++; if ({dLast, dData} !== {1'b1, 8'hF0}) $display("[TB] FAIL bp_beat1 got l=%0b d=%h want l=1 d=f0", dLast, dData); else passCount++;
        checkCount++; if (aReady !== 1'b1) $display("[TB] FAIL bp_last_ready got %0b want 1", aReady); else passCount++;
        tick();
        idleInputs();
        checkCount++; if ({dValid, dLast, dData, cOut} !== {1'b1, 1'b1, 8'hF5, 2'b01}) $display("[TB] FAIL bp_pending got v=%0b l=%0b d=%h c=%0d want 1 1 f5 1", dValid, dLast, dData, cOut); else passCount++;
        tick();
        checkCount++; if (dValid !== 1'b0 || pairCount !== 16'd6) $display("[TB] FAIL bp_end got v=%0b count=%0d want 0 6", dValid, pairCount); else passCount++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] vecA   [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
        logic [6:0] vecB   [4] = '{7'h0A, 7'h15, 7'h2B, 7'h70};
        logic [7:0] vecExp [4] = '{8'h12, 8'h24, 8'h56, 8'hE8};
        logic [1:0] vecC   [4] = '{2'b00, 2'b01, 2'b01, 2'b10};
        dReady = 1'b1;
        present(vecA[0], vecB[0], 2'd0);
        tick();
        for (int i = 0; i < 4; i++) begin
            if (i < 3) present(vecA[i+1], vecB[i+1], 2'd0);
            else idleInputs();
            checkCount++; if ({dValid, dLast, dData, cOut} !== {1'b1, 1'b1, vecExp[i], vecC[i]}) $display("[TB] FAIL b2b_beat%0d got v=%0b l=%0b d=%h c=%0d want 1 1 %h %0d", i, dValid, dLast, dData, cOut, vecExp[i], vecC[i]); else passCount++;
            tick();
        end
        checkCount++; if (dValid !== 1'b0 || pairCount !== 16'd10) $display("[TB] FAIL b2b_end got v=%0b count=%0d want 0 10", dValid, pairCount); else passCount++;

        present(8'h0E, 7'h7F, 2'd1);
        tick();
        present(8'hA5, 7'h3C, 2'd1);
        checkCount++; if (dData !== 8'hEF) $display("[TB] FAIL mix_p0b0 got %h want ef", dData); else passCount++;
        tick();
        checkCount++; if (dData !== 8'hF0 || dLast !== 1'b1) $display("[TB] FAIL mix_p0b1 got d=%h l=%0b want f0 1", dData, dLast); else passCount++;
        tick();
        idleInputs();
        checkCount++; if ({dValid, dLast, dData, cOut} !== {1'b1, 1'b0, 8'h5C, 2'b01}) $display("[TB] FAIL mix_p1b0 got v=%0b l=%0b d=%h c=%0d want 1 0 5c 1", dValid, dLast, dData, cOut); else passCount++;
        tick();
        checkCount++; if ({dValid, dLast, dData} !== {1'b1, 1'b1, 8'hCA}) $display("[TB] FAIL mix_p1b1 got v=%0b l=%0b d=%h want 1 1 ca", dValid, dLast, dData); else passCount++;
        tick();
        checkCount++; if (dValid !== 1'b0 || pairCount !== 16'd12) $display("[TB] FAIL mix_end got v=%0b count=%0d want 0 12", dValid, pairCount); else passCount++;
    endtask

    task automatic test_join();
        dReady = 1'b1;
        aValid = 1'b1; bValid = 1'b0; aData = 8'hF8; bData = 7'h00; mode = 2'd2;
        for (int i = 0; i < 5; i++) begin
            #1;
            checkCount++; if (aReady !== 1'b0 || bReady !== 1'b0 || dValid !== 1'b0) $display("[TB] FAIL join_wait%0d got a=%0b b=%0b v=%0b want 0 0 0", i, aReady, bReady, dValid); else passCount++;
            tick();
        end
        bValid = 1'b1;
        #1;
        checkCount++; if (aReady !== 1'b1 || bReady !== 1'b1) $display("[TB] FAIL join_ready got a=%0b b=%0b want 1 1", aReady, bReady); else passCount++;
        tick();
        idleInputs();
        checkCount++; if ({dValid, dData} !== {1'b1, 8'hF8}) $display("[TB] FAIL join_beat got v=%0b d=%h want 1 f8", dValid, dData); else passCount++;
        tick();
        checkCount++; if (pairCount !== 16'd13) $display("[TB] FAIL join_count got %0d want 13", pairCount); else passCount++;
    endtask

    task automatic test_reset_midburst();
        dReady = 1'b1;
        present(8'h0E, 7'h7F, 2'd1);
        tick();
        idleInputs();
        tick();
        checkCount++; if (dData !== 8'hF0 || busy !== 1'b1) $display("[TB] FAIL mid_beat1 got d=%h busy=%0b want f0 1", dData, busy); else passCount++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkCount++; if ({dValid, busy, dLast, dData, cOut} !== 13'd0) $display("[TB] FAIL mid_rst_out got v=%0b busy=%0b l=%0b d=%h c=%0d want all 0", dValid, busy, dLast, dData, cOut); else passCount++;
        checkCount++; if (pairCount !== 16'd0 || pairCountW !== 2'd0) $display("[TB] FAIL mid_rst_count got %0d/%0d want 0/0", pairCount, pairCountW); else passCount++;
        tick();
        checkCount++; if (dValid !== 1'b0 || pairCount !== 16'd0) $display("[TB] FAIL mid_discard got v=%0b count=%0d want 0 0", dValid, pairCount); else passCount++;
    endtask

    initial begin
        rst = 1'b1; aValid = 1'b0; bValid = 1'b0; aData = '0; bData = '0; mode = '0; dReady = 1'b0;
        test_reset();
        test_swap2();
        test_single_modes();
        test_backpressure();
        test_back_to_back();
        test_join();
        test_reset_midburst();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
